// File: rtl/mul4_fitness_eval.sv
// mul4_fitness_eval
//   Drives an evolved 4-lane multiplier individual with LFSR-generated 32x32
//   operand pairs. A serial shift-add multiplier computes the golden 64-bit
//   product. The block counts how many of the individual's 64 output bits
//   match that product and accumulates the result into a fitness score.
// Ports
//   clk, rst_n               : clock, asynchronous active-low reset
//   start                    : run request, sampled only in IDLE
//   busy, done               : run in progress / one-cycle end-of-run pulse
//   dut_a1..dut_b0           : operand lanes to the individual, a={a1,a0}, b={b1,b0}
//   dut_y3..dut_y0           : individual output lanes, combinational from dut_*
//   score, exact_count       : matching-bit total (saturating) / fully exact vectors
module mul4_fitness_eval #(
  parameter int unsigned NUM_VECTORS = 64,
  parameter logic [31:0] SEED        = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] dut_a1,
  output logic [15:0] dut_a0,
  output logic [15:0] dut_b1,
  output logic [15:0] dut_b0,
  input  logic [15:0] dut_y3,
  input  logic [15:0] dut_y2,
  input  logic [15:0] dut_y1,
  input  logic [15:0] dut_y0,
  output logic [15:0] score,
  output logic [15:0] exact_count
);

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  // An all-zero Galois LFSR never leaves zero.
  localparam logic [31:0] SEED_INIT = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [9:0]  LAST_VEC  = 10'(NUM_VECTORS - 1);

  typedef enum logic [2:0] {IDLE, GEN_A, GEN_B, MUL, CMP, DONE} state_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'd0);
  endfunction

  function automatic logic [6:0] match_count(input logic [63:0] obs,
                                             input logic [63:0] exp);
    logic [6:0] n;
    n = 7'd0;
    for (int i = 0; i < 64; i++) begin
      if (obs[i] == exp[i]) n = n + 7'd1;
    end
    return n;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] acc,
                                          input logic [6:0]  inc);
    logic [16:0] sum;
    sum = {1'b0, acc} + {10'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  state_t      state, state_nxt;
  logic [31:0] lfsr;
  logic [31:0] a_reg, b_reg;
  logic [9:0]  vec_cnt;
  logic [4:0]  iter;
  logic [63:0] prod;
  logic [31:0] mplier;
  logic [32:0] mul_sum;
  logic [6:0]  match;

  assign dut_a1 = a_reg[31:16];
  assign dut_a0 = a_reg[15:0];
  assign dut_b1 = b_reg[31:16];
  assign dut_b0 = b_reg[15:0];

  assign busy = (state == GEN_A) || (state == GEN_B) || (state == MUL) || (state == CMP);
  assign done = (state == DONE);

  // Right-shifting product register: the upper half accumulates the
  // multiplicand, and one finished product bit falls into the lower half per
  // iteration. The multiplicand is read straight from the stable operand port.
  assign mul_sum = {1'b0, prod[63:32]} + (mplier[0] ? {1'b0, a_reg} : 33'd0);
  assign match   = match_count({dut_y3, dut_y2, dut_y1, dut_y0}, prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = GEN_A;
      GEN_A:   state_nxt = GEN_B;
      GEN_B:   state_nxt = MUL;
      MUL:     if (iter == 5'd31) state_nxt = CMP;
      CMP:     state_nxt = (vec_cnt == LAST_VEC) ? DONE : GEN_A;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr        <= SEED_INIT;
      a_reg       <= 32'd0;
      b_reg       <= 32'd0;
      vec_cnt     <= 10'd0;
      iter        <= 5'd0;
      score       <= 16'd0;
      exact_count <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            lfsr        <= SEED_INIT;
            vec_cnt     <= 10'd0;
            score       <= 16'd0;
            exact_count <= 16'd0;
          end
        end
        GEN_A: begin
          lfsr  <= lfsr_step(lfsr);
          a_reg <= lfsr_step(lfsr);
        end
        GEN_B: begin
          lfsr  <= lfsr_step(lfsr);
          b_reg <= lfsr_step(lfsr);
          iter  <= 5'd0;
        end
        MUL: iter <= iter + 5'd1;
        CMP: begin
          score   <= sat_add(score, match);
          vec_cnt <= vec_cnt + 10'd1;
          if (match == 7'd64) exact_count <= exact_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Multiplier datapath needs no reset: it is always reloaded in GEN_B
  // before it is used.
  always_ff @(posedge clk) begin
    case (state)
      GEN_B: begin
        prod   <= 64'd0;
        mplier <= lfsr_step(lfsr);
      end
      MUL: begin
        prod   <= {mul_sum, prod[31:1]};
        mplier <= mplier >> 1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mul4_fitness_eval.sv
module tb_mul4_fitness_eval;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start1, start4;
  logic [1:0]  mode;
  logic [63:0] key;

  logic        busy1, done1, busy4, done4;
  logic [15:0] a1_1, a0_1, b1_1, b0_1, a1_4, a0_4, b1_4, b0_4;
  logic [15:0] sc1, ex1, sc4, ex4;
  logic [63:0] y_1, y_4;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_a [4];
  logic [31:0] exp_b [4];
  logic [15:0] saved_score;

  // Individual under evaluation: 0 = correct multiplier, 1 = every bit wrong,
  // 2 = outputs stuck at 0, 3 = correct product with operand-dependent errors.
  function automatic logic [63:0] y_of(input logic [1:0] md, input logic [31:0] a,
                                       input logic [31:0] b, input logic [63:0] k);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (md)
      2'd0:    return p;
      2'd1:    return ~p;
      2'd2:    return 64'd0;
      default: return p ^ (k & {a, b} & ({a, b} >> 3));
    endcase
  endfunction

  always_comb y_1 = y_of(mode, {a1_1, a0_1}, {b1_1, b0_1}, key);
  always_comb y_4 = y_of(mode, {a1_4, a0_4}, {b1_4, b0_4}, key);

  mul4_fitness_eval #(.NUM_VECTORS(1), .SEED(32'h0000_0001)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .dut_a1(a1_1), .dut_a0(a0_1), .dut_b1(b1_1), .dut_b0(b0_1),
    .dut_y3(y_1[63:48]), .dut_y2(y_1[47:32]), .dut_y1(y_1[31:16]), .dut_y0(y_1[15:0]),
    .score(sc1), .exact_count(ex1)
  );

  mul4_fitness_eval #(.NUM_VECTORS(4), .SEED(32'h0000_0001)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .busy(busy4), .done(done4),
    .dut_a1(a1_4), .dut_a0(a0_4), .dut_b1(b1_4), .dut_b0(b0_4),
    .dut_y3(y_4[63:48]), .dut_y2(y_4[47:32]), .dut_y1(y_4[31:16]), .dut_y0(y_4[15:0]),
    .score(sc4), .exact_count(ex4)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: regenerate the operand sequence from the LFSR rule, multiply
  // with native arithmetic and count matching bits of the individual's answer.
  task automatic model(input int n, input logic [1:0] md,
                       output logic [15:0] es, output logic [15:0] ee);
    logic [31:0] s;
    logic [63:0] p;
    int m, total, exact;
    s = 32'd1; total = 0; exact = 0;
    for (int v = 0; v < n; v++) begin
      s = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'd0);
      exp_a[v] = s;
      s = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'd0);
      exp_b[v] = s;
      p = {32'd0, exp_a[v]} * {32'd0, exp_b[v]};
      m = $countones(~(y_of(md, exp_a[v], exp_b[v], key) ^ p));
      total += m;
      if (m == 64) exact++;
    end
    es = (total > 65535) ? 16'hFFFF : 16'(total);
    ee = 16'(exact);
  endtask

  task automatic set_start(input bit big, input logic v);
    if (big) start4 = v; else start1 = v;
  endtask

  task automatic run(input bit big, input int n, input logic [1:0] md,
                     input bit inject, input string tag);
    logic [15:0] es, ee;
    logic        b_busy, b_done;
    logic [31:0] b_a, b_b;
    int done_cyc, pulses, busy_bad, op_bad;
    mode = md;
    model(n, md, es, ee);
    done_cyc = 0; pulses = 0; busy_bad = 0; op_bad = 0;
    @(negedge clk);
    set_start(big, 1'b1);
    for (int k = 1; k <= 35 * n + 4; k++) begin
      @(negedge clk);
      set_start(big, inject && (k == 10 || k == 35 * n + 1));
      b_busy = big ? busy4 : busy1;
      b_done = big ? done4 : done1;
      b_a    = big ? {a1_4, a0_4} : {a1_1, a0_1};
      b_b    = big ? {b1_4, b0_4} : {b1_1, b0_1};
      if (b_done) begin
        pulses++;
        if (done_cyc == 0) done_cyc = k;
      end
      if (b_busy !== (k <= 35 * n)) busy_bad++;
      for (int v = 0; v < n; v++) begin
        if (k == 35 * v + 2 && b_a !== exp_a[v]) op_bad++;
        if (k == 35 * v + 3 && b_b !== exp_b[v]) op_bad++;
      end
      if (k == 35 * n + 1) begin
        check_eq({tag, "_score"}, big ? sc4 : sc1, es);
        check_eq({tag, "_exact"}, big ? ex4 : ex1, ee);
      end
    end
    set_start(big, 1'b0);
    check_eq({tag, "_done_cycle"}, done_cyc, 35 * n + 1);
    check_eq({tag, "_done_pulses"}, pulses, 1);
    check_eq({tag, "_busy_profile_errs"}, busy_bad, 0);
    check_eq({tag, "_operand_errs"}, op_bad, 0);
    check_eq({tag, "_score_held"}, big ? sc4 : sc1, es);
  endtask

  initial begin
    rst_n = 1'b0; start1 = 1'b0; start4 = 1'b0; mode = 2'd0; key = 64'd0;

    // Reset with random start activity
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start1 = 1'($urandom); start4 = 1'($urandom);
    end
    check_eq("rst_busy4", busy4, 0);
    check_eq("rst_done4", done4, 0);
    check_eq("rst_score4", sc4, 0);
    check_eq("rst_exact4", ex4, 0);
    check_eq("rst_ops4", {a1_4, a0_4, b1_4, b0_4}, 64'd0);
    check_eq("rst_busy1", busy1, 0);
    start1 = 1'b0; start4 = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("idle_hold_busy", {busy4, busy1}, 0);
    check_eq("idle_hold_done", {done4, done1}, 0);

    // Single vector against a correct individual
    run(1'b0, 1, 2'd0, 1'b0, "n1_golden");
    check_eq("n1_first_a", {a1_1, a0_1}, 64'h8020_0003);
    check_eq("n1_first_b", {b1_1, b0_1}, 64'hC030_0002);
    check_eq("n1_score64", sc1, 64);
    check_eq("n1_exact1", ex1, 1);

    // Every bit wrong, then outputs stuck at zero
    run(1'b1, 4, 2'd1, 1'b0, "n4_inverted");
    check_eq("n4_inverted_zero", {sc4, ex4}, 0);
    run(1'b1, 4, 2'd2, 1'b0, "n4_zero");

    // Random error pattern, start pulsed in MUL and DONE, then repeated
    key = {$urandom, $urandom};
    run(1'b1, 4, 2'd3, 1'b1, "n4_inject");
    saved_score = sc4;
    run(1'b1, 4, 2'd3, 1'b0, "n4_repeat");
    check_eq("repeat_same_score", sc4, saved_score);

    // Reset in cycle 20 of vector 2
    @(negedge clk); start4 = 1'b1;
    for (int k = 1; k <= 55; k++) begin
      @(negedge clk);
      start4 = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", busy4, 0);
    check_eq("midrst_score", sc4, 0);
    check_eq("midrst_exact", ex4, 0);
    check_eq("midrst_ops", {a1_4, a0_4, b1_4, b0_4}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    run(1'b1, 4, 2'd3, 1'b0, "n4_after_rst");
    check_eq("after_rst_same_score", sc4, saved_score);

    // More random individuals
    for (int r = 0; r < 3; r++) begin
      key = {$urandom, $urandom};
      run(1'b1, 4, 2'd3, 1'b0, "n4_random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
